// File: rtl/jump_pkg.sv
// Shared constants and state encoding for the jump game front-end.
// Also consumed by wechat_jump_fsm and jump.
package jump_pkg;
    localparam int MAX_SQUEEZE = 14;
    localparam int SQ_W        = 4;   // squeeze level width
    localparam int VEL_W       = 11;  // launch velocity width

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHARGE   = 2'd1,
        ST_WAIT_REL = 2'd2
    } charge_state_e;
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce counter for a raw push-button.
//   clk, rst : block clock, synchronous active-high reset
//   i_btn    : raw asynchronous button
//   o_level  : debounced level; flips after DB_TICKS stable synced cycles
module btn_debounce #(
    parameter int DB_TICKS = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level
);
    localparam int CW = ($clog2(DB_TICKS) > 0) ? $clog2(DB_TICKS) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          btn_s;

    assign btn_s = sync_q[1];

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (btn_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB_TICKS - 1)) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_btn};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign o_level = level_q;
endmodule

// File: rtl/btn_charge.sv
// Button front-end: debounces the button, measures hold time as a squeeze
// level and emits a launch velocity pulse on release.
//   clk, rst     : block clock, synchronous active-high reset
//   i_btn        : raw button;  i_enable : FSM ready to accept a charge
//   o_btn_level  : debounced level
//   o_squeeze    : squeeze level while charging, 0 otherwise
//   o_charging   : high in CHARGE
//   o_release    : one-cycle pulse at end of a charge
//   o_v_init     : velocity latched with o_release
module btn_charge
    import jump_pkg::*;
#(
    parameter int DB_TICKS    = 500000,
    parameter int TICK_DIV    = 1666666,
    parameter int MAX_SQUEEZE = jump_pkg::MAX_SQUEEZE,
    parameter int V_BASE      = 100,
    parameter int V_STEP      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_btn,
    input  logic             i_enable,
    output logic             o_btn_level,
    output logic [SQ_W-1:0]  o_squeeze,
    output logic             o_charging,
    output logic             o_release,
    output logic [VEL_W-1:0] o_v_init
);
    localparam int PW = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;

    charge_state_e    state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [SQ_W-1:0]  sq_q, sq_d;
    logic             rel_q, rel_d;
    logic             chg_q;
    logic [VEL_W-1:0] v_q, v_d;
    logic             lvl;

    btn_debounce #(.DB_TICKS(DB_TICKS)) u_db (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (i_btn),
        .o_level (lvl)
    );

    // Squeeze is held at 0 outside CHARGE so it can drive o_squeeze directly.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sq_d    = sq_q;
        rel_d   = 1'b0;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                sq_d    = '0;
                if (lvl) state_d = i_enable ? ST_CHARGE : ST_WAIT_REL;
            end
            ST_CHARGE: begin
                // Enable drop outranks release; release outranks increment.
                if (!i_enable) begin
                    state_d = ST_WAIT_REL;
                    presc_d = '0;
                    sq_d    = '0;
                end else if (!lvl) begin
                    state_d = ST_IDLE;
                    rel_d   = 1'b1;
                    v_d     = VEL_W'(V_BASE) + VEL_W'(sq_q) * VEL_W'(V_STEP);
                    presc_d = '0;
                    sq_d    = '0;
                end else if (presc_q == PW'(TICK_DIV - 1)) begin
                    presc_d = '0;
                    if (sq_q != SQ_W'(MAX_SQUEEZE)) sq_d = sq_q + SQ_W'(1);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_WAIT_REL: begin
                if (!lvl) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            sq_q    <= '0;
            rel_q   <= 1'b0;
            chg_q   <= 1'b0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sq_q    <= sq_d;
            rel_q   <= rel_d;
            chg_q   <= (state_d == ST_CHARGE);
            v_q     <= v_d;
        end
    end

    assign o_btn_level = lvl;
    assign o_squeeze   = sq_q;
    assign o_charging  = chg_q;
    assign o_release   = rel_q;
    assign o_v_init    = v_q;
endmodule

// File: doc/btn_charge.md
# btn_charge

Button front-end for the jump game, directly upstream of `wechat_jump_fsm`. It synchronises and debounces the raw push-button, then measures how long the player holds it. While held it drives a 0–14 squeeze level. On release it emits a one-cycle pulse with the launch velocity derived from that level. It runs on the same divided clock as the FSM.

## Interface
Parameters:
- `DB_TICKS`, 500000 — consecutive stable cycles required to accept a new button level (20 ms at 25 MHz).
- `TICK_DIV`, 1666666 — cycles per squeeze increment (≈67 ms).
- `MAX_SQUEEZE`, 14 — saturation value of the squeeze level.
- `V_BASE`, 100 — launch velocity at squeeze 0.
- `V_STEP`, 20 — velocity added per squeeze step. Constraint: `V_BASE + MAX_SQUEEZE*V_STEP ≤ 2047`.

Ports:
- `clk`  in  1  block clock (div_res[1] domain).
- `rst`  in  1  reset; synchronous, active-high.
- `i_btn`  in  1  raw asynchronous button, active-high.
- `i_enable`  in  1  FSM is ready to accept a charge (idle-on-block state).
- `o_btn_level`  out  1  debounced button level.
- `o_squeeze`  out  4  current squeeze level, 0..MAX_SQUEEZE.
- `o_charging`  out  1  high while in CHARGE.
- `o_release`  out  1  one-cycle pulse when a charge completes.
- `o_v_init`  out  11  launch velocity; updated with `o_release` and held until the next release.

## Operation
- Synchroniser: 2-FF chain on `i_btn` produces `btn_s`.
- Debounce:
  - Counter resets whenever `btn_s == o_btn_level`.
  - Otherwise the counter increments.
  - When it reaches `DB_TICKS-1`, `o_btn_level` toggles and the counter clears.
- State machine (encoded IDLE, CHARGE, WAIT_REL):
  - IDLE: on a debounced rise with `i_enable=1`, go to CHARGE and clear the squeeze level and prescaler. On a debounced rise with `i_enable=0`, go to WAIT_REL.
  - CHARGE: the prescaler counts 0..TICK_DIV-1 and wraps. On wrap, squeeze increments, saturating at MAX_SQUEEZE.
    - Debounced fall: pulse `o_release`, latch `o_v_init = V_BASE + squeeze*V_STEP`, return to IDLE.
    - `i_enable` drops: abort to WAIT_REL with no pulse.
  - WAIT_REL: on debounced low, go to IDLE. A press must be released before a new charge can start.
- `o_squeeze` equals the squeeze level in CHARGE and is 0 in every other state.
- Arithmetic: the multiply is done at 11 bits. No overflow is possible given the parameter constraint.
- Precedence when events coincide in the same cycle:
  - Release beats increment; the captured level is the pre-increment value.
  - An `i_enable` drop beats release; the charge aborts with no pulse.
- Reset: all outputs, counters and debounce state go to 0; state goes to IDLE.
  - A button held through reset is seen as a fresh press after `DB_TICKS` cycles.
  - That press charges only if `i_enable=1`.

## Timing
- Raw edge to `o_btn_level` change: 2 sync cycles plus `DB_TICKS` cycles.
- `o_btn_level` rise to `o_charging`/state change: 1 cycle (registered FSM).
- `o_btn_level` fall to `o_release` high: 1 cycle. `o_release` lasts exactly 1 cycle.
- `o_v_init` changes in the same cycle `o_release` is asserted, then stays stable.
- `o_squeeze` updates 1 cycle after each prescaler wrap and returns to 0 in the cycle after release.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `jump_pkg`:
  - `MAX_SQUEEZE` constant
  - squeeze width (4)
  - velocity width (11)
  - FSM state encoding
  - These are also consumed by `wechat_jump_fsm` and `jump`.
- Sub-module `btn_debounce`: synchroniser plus debounce counter. Parameter `DB_TICKS`; output `o_level`.
- The top-level `btn_charge` holds the FSM, prescaler, squeeze counter and velocity latch.

## Test plan
Bench parameters: `DB_TICKS=4`, `TICK_DIV=8`, `V_BASE=100`, `V_STEP=20`.
- Bounce: 3-cycle high glitches on `i_btn` → `o_btn_level` stays 0, no `o_charging`, no `o_release`.
- Normal charge: enable=1, hold 30 cycles past debounce → `o_squeeze` reaches 3; on release, one `o_release` pulse with `o_v_init=160`, then `o_squeeze=0`.
- Saturation: hold 200 cycles → `o_squeeze` stops at 14; release gives `o_v_init=380`.
- Abort: drop `i_enable` mid-charge → `o_squeeze` goes to 0 with no pulse. Re-press without releasing → no charge. Release, then press again with enable=1 → normal charge.
- Coincidence: debounced fall in the same cycle as a prescaler wrap at squeeze 5 → `o_v_init=200`, not 220.
- Reset mid-charge: assert `rst` for 1 cycle while the button is held → next cycle all outputs are 0. After 6 cycles `o_btn_level=1` and a new charge starts.
